// File: rtl/spike_gen_scheduler_if.sv
// Valid/ack channel used for the program-write input and the tag output.
// The master drives data and valid, and the slave returns ack.
interface spike_gen_scheduler_if #(
  parameter int W = 8
);
  logic [W-1:0] d;
  logic         v;
  logic         a;

  modport master (output d, output v, input a);
  modport slave  (input d, input v, output a);
endinterface

// File: rtl/spike_gen_scheduler.sv
// Spike generator sequencer: sweeps the program memory on every time-unit pulse and emits the tags of firing generators.
// Optional feature: define SG_EMIT_COUNT_EN to add a saturating 32-bit emit_count output.
module spike_gen_scheduler #(
  parameter int N_SG_gens   = 8,
  parameter int N_SG_period = 16,
  parameter int N_SG_tag    = 11
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    time_unit_pulse,
  input  logic [N_SG_gens-1:0]    gens_used,
  input  logic [2**N_SG_gens-1:0] gens_en,
  spike_gen_scheduler_if.slave    prog,
  spike_gen_scheduler_if.master   tag_out,
  output logic                    overrun
`ifdef SG_EMIT_COUNT_EN
  ,
  output logic [31:0]             emit_count
`endif
);

  localparam int DEPTH = 2**N_SG_gens;
  localparam int EW    = 2*N_SG_period + N_SG_tag;

  typedef enum logic [1:0] {IDLE, RD, EVAL, EMIT} state_e;

  state_e                 state_q;
  logic [N_SG_gens-1:0]   idx_q;
  logic [N_SG_gens-1:0]   usedSnap_q;
  logic                   pending_q;
  logic                   overrun_q;
  logic                   tagValid_q;
  logic [N_SG_tag-1:0]    tagData_q;
  logic [EW-1:0]          mem [DEPTH];
  logic [EW-1:0]          rdata_q;

  logic [N_SG_gens-1:0]   progIdx;
  logic [EW-1:0]          progEntry;
  logic [N_SG_period-1:0] rdPeriod;
  logic [N_SG_period-1:0] rdTicks;
  logic [N_SG_tag-1:0]    rdTag;
  logic [N_SG_period-1:0] ticks_d;
  logic                   startReq;
  logic                   progAck;
  logic                   evalActive;
  logic                   fire;
  logic                   lastIdx;

  assign {progIdx, progEntry}     = prog.d;
  assign {rdPeriod, rdTicks, rdTag} = rdata_q;

  // A pending or fresh pulse always takes priority over a program write.
  assign startReq   = time_unit_pulse || pending_q;
  assign progAck    = !reset && (state_q == IDLE) && !startReq && prog.v;
  assign evalActive = gens_en[idx_q] && (rdPeriod != '0);
  assign fire       = evalActive && (rdTicks == '0);
  assign ticks_d    = fire ? (rdPeriod - N_SG_period'(1)) : (rdTicks - N_SG_period'(1));
  assign lastIdx    = (idx_q == (usedSnap_q - N_SG_gens'(1)));

  assign prog.a    = progAck;
  assign tag_out.v = tagValid_q;
  assign tag_out.d = tagData_q;
  assign overrun   = overrun_q;

  // Program memory has no reset so stored tick counts survive a reset.
  always_ff @(posedge clk) begin
    if (progAck) begin
      mem[progIdx] <= progEntry;
    end else if (!reset && (state_q == EVAL) && evalActive) begin
      mem[idx_q] <= {rdPeriod, ticks_d, rdTag};
    end
    rdata_q <= mem[idx_q];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      usedSnap_q <= '0;
      pending_q  <= 1'b0;
      overrun_q  <= 1'b0;
      tagValid_q <= 1'b0;
      tagData_q  <= '0;
    end else begin
      // Only one pulse can be held while a sweep runs; a second one is lost.
      if ((state_q != IDLE) && time_unit_pulse) begin
        if (pending_q) begin
          overrun_q <= 1'b1;
        end else begin
          pending_q <= 1'b1;
        end
      end
      case (state_q)
        IDLE: begin
          if (startReq) begin
            pending_q <= 1'b0;
            if (gens_used != '0) begin
              usedSnap_q <= gens_used;
              idx_q      <= '0;
              state_q    <= RD;
            end
          end
        end
        RD: begin
          state_q <= EVAL;
        end
        EVAL: begin
          if (fire) begin
            tagData_q  <= rdTag;
            tagValid_q <= 1'b1;
            state_q    <= EMIT;
          end else if (lastIdx) begin
            state_q <= IDLE;
          end else begin
            idx_q   <= idx_q + N_SG_gens'(1);
            state_q <= RD;
          end
        end
        EMIT: begin
          if (tag_out.a) begin
            tagValid_q <= 1'b0;
            if (lastIdx) begin
              state_q <= IDLE;
            end else begin
              idx_q   <= idx_q + N_SG_gens'(1);
              state_q <= RD;
            end
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

`ifdef SG_EMIT_COUNT_EN
  logic [31:0] emitCount_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      emitCount_q <= '0;
    end else if (tagValid_q && tag_out.a && (emitCount_q != '1)) begin
      emitCount_q <= emitCount_q + 32'd1;
    end
  end

  assign emit_count = emitCount_q;
`endif

endmodule

// File: tb/tb_spike_gen_scheduler.sv
// Directed bench for spike_gen_scheduler: an array model of the generator program predicts the tag stream.
// Literal per-pulse expectations pin the model.
module tb_spike_gen_scheduler;

  logic         clk;
  logic         reset;
  logic         timeUnitPulse;
  logic [7:0]   gensUsed;
  logic [255:0] gensEn;
  logic         overrun;
`ifdef SG_EMIT_COUNT_EN
  logic [31:0]  emitCount;
`endif

  spike_gen_scheduler_if #(.W(51)) progIf ();
  spike_gen_scheduler_if #(.W(11)) tagIf ();

  spike_gen_scheduler dut (
    .clk             (clk),
    .reset           (reset),
    .time_unit_pulse (timeUnitPulse),
    .gens_used       (gensUsed),
    .gens_en         (gensEn),
    .prog            (progIf),
    .tag_out         (tagIf),
    .overrun         (overrun)
`ifdef SG_EMIT_COUNT_EN
    ,
    .emit_count      (emitCount)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [15:0] mPeriod [256];
  logic [15:0] mTicks  [256];
  logic [10:0] mTag    [256];
  logic [10:0] expQ    [$];
  logic [10:0] gotTags [$];
  int          gotCount = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual %0h required %0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // One sweep of the whole program: each enabled, non-zero-period generator fires when its count hits zero.
  task automatic modelSweep();
    for (int g = 0; g < int'(gensUsed); g++) begin
      if (gensEn[g] && mPeriod[g] != 16'd0) begin
        if (mTicks[g] == 16'd0) begin
          expQ.push_back(mTag[g]);
          mTicks[g] = mPeriod[g] - 16'd1;
        end else begin
          mTicks[g] = mTicks[g] - 16'd1;
        end
      end
    end
  endtask

  task automatic applyStimulus(input bit counted);
    timeUnitPulse = 1'b1;
    if (counted) modelSweep();
    tick();
    timeUnitPulse = 1'b0;
  endtask

  task automatic progWrite(input int g, input logic [15:0] p, input logic [15:0] t, input logic [10:0] tg);
    bit acked = 1'b0;
    progIf.d = {8'(g), p, t, tg};
    progIf.v = 1'b1;
    for (int i = 0; i < 100 && !acked; i++) begin
      if (progIf.a) acked = 1'b1;
      else tick();
    end
    if (!acked) begin
      checks++;
      errors++;
      $display("[TB] FAIL prog write gen %0d: actual no ack required ack within 100 cycles", g);
    end else begin
      tick();
      mPeriod[g] = p;
      mTicks[g]  = t;
      mTag[g]    = tg;
    end
    progIf.v = 1'b0;
  endtask

  task automatic waitTagValid(input int budget, input string name);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      if (tagIf.v) seen = 1'b1;
      else tick();
    end
    checkOutput(name, 64'(seen), 64'd1);
  endtask

  task automatic pulseAndCount(input int expectEmits, input int settle, input string name);
    int c0 = gotCount;
    applyStimulus(1'b1);
    ticks(settle);
    checkOutput(name, 64'(gotCount - c0), 64'(expectEmits));
  endtask

  // Scoreboard: every handshake must match the model's next tag, and a stalled tag must hold still.
  logic        prevV = 1'b0;
  logic        prevA = 1'b0;
  logic [10:0] prevD = '0;
  always @(negedge clk) begin
    if (reset) begin
      prevV = 1'b0;
    end else begin
      if (tagIf.v && prevV && !prevA) checkOutput("tag_out_d stable", 64'(tagIf.d), 64'(prevD));
      if (tagIf.v && tagIf.a) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected emission: actual %0h required none", tagIf.d);
        end else begin
          checkOutput("tag stream", 64'(tagIf.d), 64'(expQ.pop_front()));
        end
        gotTags.push_back(tagIf.d);
        gotCount++;
      end
      prevV = tagIf.v;
      prevA = tagIf.a;
      prevD = tagIf.d;
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: actual timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int  c0;
    int  sIdx;
    bit  bad;
    reset         = 1'b1;
    timeUnitPulse = 1'b0;
    gensUsed      = '0;
    gensEn        = '0;
    progIf.d      = '0;
    progIf.v      = 1'b0;
    tagIf.a       = 1'b1;
    ticks(3);
    reset = 1'b0;
    checkOutput("reset tag_out_v", 64'(tagIf.v), 64'd0);
    checkOutput("reset tag_out_d", 64'(tagIf.d), 64'd0);
    checkOutput("reset overrun", 64'(overrun), 64'd0);
    checkOutput("reset prog_a", 64'(progIf.a), 64'd0);

    $display("[TB] period 3 on gen 0");
    gensUsed = 8'd1;
    gensEn   = 256'd1;
    progWrite(0, 16'd3, 16'd0, 11'h055);
    c0 = gotCount;
    applyStimulus(1'b1);
    tick();
    checkOutput("latency edge k+1 valid", 64'(tagIf.v), 64'd0);
    tick();
    checkOutput("latency edge k+2 valid", 64'(tagIf.v), 64'd1);
    checkOutput("latency edge k+2 tag", 64'(tagIf.d), 64'h055);
    ticks(6);
    checkOutput("p3 pulse 1 emits", 64'(gotCount - c0), 64'd1);
    pulseAndCount(0, 8, "p3 pulse 2 emits");
    pulseAndCount(0, 8, "p3 pulse 3 emits");
    pulseAndCount(1, 8, "p3 pulse 4 emits");
    pulseAndCount(0, 8, "p3 pulse 5 emits");
    pulseAndCount(0, 8, "p3 pulse 6 emits");
    pulseAndCount(1, 8, "p3 pulse 7 emits");

    $display("[TB] four generators with gen 2 disabled");
    gensUsed = 8'd4;
    gensEn   = 256'b1011;
    for (int g = 0; g < 4; g++) progWrite(g, 16'd1, 16'd0, 11'(8'h10 + g));
    sIdx = gotTags.size();
    pulseAndCount(3, 20, "mask sweep emits");
    checkOutput("mask order 0", 64'(gotTags[sIdx]), 64'h010);
    checkOutput("mask order 1", 64'(gotTags[sIdx+1]), 64'h011);
    checkOutput("mask order 2", 64'(gotTags[sIdx+2]), 64'h013);

    $display("[TB] program write against a sweep");
    progIf.d      = {8'd10, 16'd2, 16'd1, 11'h0AA};
    progIf.v      = 1'b1;
    timeUnitPulse = 1'b1;
    modelSweep();
    #1;
    checkOutput("prog_a with pulse", 64'(progIf.a), 64'd0);
    tick();
    timeUnitPulse = 1'b0;
    bad = 1'b0;
    for (int j = 0; j < 11; j++) begin
      if (progIf.a) bad = 1'b1;
      tick();
    end
    checkOutput("prog_a low during sweep", 64'(bad), 64'd0);
    checkOutput("prog_a first idle cycle", 64'(progIf.a), 64'd1);
    tick();
    progIf.v    = 1'b0;
    mPeriod[10] = 16'd2;
    mTicks[10]  = 16'd1;
    mTag[10]    = 11'h0AA;
    ticks(4);
    gensUsed = 8'd11;
    gensEn   = (256'd1 << 10) | (256'd1 << 2);
    pulseAndCount(1, 40, "late write pulse 1 emits");
    checkOutput("gen 2 untouched tag", 64'(gotTags[gotTags.size()-1]), 64'h012);
    pulseAndCount(2, 40, "late write pulse 2 emits");
    checkOutput("late write tag", 64'(gotTags[gotTags.size()-1]), 64'h0AA);

    $display("[TB] backpressure and overrun");
    gensUsed = 8'd1;
    gensEn   = 256'd1;
    progWrite(0, 16'd1, 16'd0, 11'h020);
    tagIf.a = 1'b0;
    applyStimulus(1'b1);
    waitTagValid(10, "bp first valid");
    checkOutput("bp tag", 64'(tagIf.d), 64'h020);
    for (int i = 0; i < 20; i++) begin
      if (i == 4) begin
        applyStimulus(1'b1);
        checkOutput("overrun after first extra", 64'(overrun), 64'd0);
      end else if (i == 9) begin
        applyStimulus(1'b0);
        checkOutput("overrun after second extra", 64'(overrun), 64'd1);
      end else begin
        tick();
      end
    end
    tagIf.a = 1'b1;
    tick();
    checkOutput("bp valid drops after ack", 64'(tagIf.v), 64'd0);
    ticks(3);
    checkOutput("pending sweep immediate", 64'(tagIf.v), 64'd1);
    ticks(5);
    checkOutput("overrun sticky", 64'(overrun), 64'd1);

    $display("[TB] reset during emit of gen 5");
    gensUsed = 8'd6;
    gensEn   = 256'd1 << 5;
    progWrite(5, 16'd3, 16'd0, 11'h155);
    tagIf.a = 1'b0;
    applyStimulus(1'b1);
    waitTagValid(30, "gen 5 valid");
    checkOutput("gen 5 tag", 64'(tagIf.d), 64'h155);
    ticks(3);
    reset = 1'b1;
    expQ.delete();
    tick();
    reset = 1'b0;
    checkOutput("mid-emit reset valid", 64'(tagIf.v), 64'd0);
    checkOutput("mid-emit reset overrun", 64'(overrun), 64'd0);
    checkOutput("mid-emit reset tag", 64'(tagIf.d), 64'd0);
    tagIf.a = 1'b1;
    pulseAndCount(0, 20, "gen 5 resume pulse 1");
    pulseAndCount(0, 20, "gen 5 resume pulse 2");
    pulseAndCount(1, 20, "gen 5 resume pulse 3");
    checkOutput("gen 5 resume tag", 64'(gotTags[gotTags.size()-1]), 64'h155);

    $display("[TB] empty sweep and emission count");
    reset = 1'b1;
    tick();
    reset = 1'b0;
`ifdef SG_EMIT_COUNT_EN
    checkOutput("emit_count after reset", 64'(emitCount), 64'd0);
`endif
    gensUsed = 8'd0;
    applyStimulus(1'b1);
    bad = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (tagIf.v) bad = 1'b1;
      tick();
    end
    checkOutput("gens_used 0 no valid", 64'(bad), 64'd0);
`ifdef SG_EMIT_COUNT_EN
    checkOutput("emit_count gens_used 0", 64'(emitCount), 64'd0);
`endif
    gensUsed = 8'd1;
    gensEn   = 256'd1;
    progWrite(0, 16'd2, 16'd0, 11'h033);
    c0 = gotCount;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1);
      ticks(8);
    end
    checkOutput("period 2 ten pulses", 64'(gotCount - c0), 64'd5);
`ifdef SG_EMIT_COUNT_EN
    checkOutput("emit_count ten pulses", 64'(emitCount), 64'd5);
`endif

    checkOutput("model queue drained", 64'(expQ.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
